// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receiver: packet field layout and frame FSM states.
package ps2_pkg;

    localparam int STATUS_LSB      = 0;
    localparam int X_LSB           = 8;
    localparam int Y_LSB           = 16;
    localparam int TOGGLE_BIT      = 24;
    localparam int PACKET_W        = TOGGLE_BIT + 1;
    localparam int STATUS_SYNC_BIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } frame_state_e;

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Packet bus published by the PS/2 mouse receiver and read by the mouse emulation blocks.
interface ps2_mouse_rx_if;
    import ps2_pkg::*;

    logic [PACKET_W-1:0] ps2_mouse;
    logic                frame_err;

    modport master (output ps2_mouse, output frame_err);
    modport slave  (input  ps2_mouse, input  frame_err);

endinterface

// File: rtl/ps2_byte_rx.sv
// PS/2 line synchronizer, falling-edge detector, 11-bit frame FSM and inactivity timeout.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       busy,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err,
    output logic       timeout
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   fall_data;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         par_q, par_d;
    logic         valid_d, err_d, timeout_d;
    logic [CW-1:0] tmo_cnt;
    logic         active;
    logic         timeout_hit;

    // Idle-high lines reset to 1 so a release of reset never looks like a falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
            fall_data <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            fall_data <= data_sync[SYNC_STAGES-1];
        end
    end

    assign active      = (state_q != IDLE) || busy;
    assign timeout_hit = active && !fall && (tmo_cnt == TMO_MAX);

    // Counter restarts on the hit so a lingering busy flag cannot fire a second timeout.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (fall || timeout_hit) begin
            tmo_cnt <= '0;
        end else if (active && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            byte_valid <= valid_d;
            err        <= err_d;
            timeout    <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        if (timeout_hit) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            timeout_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!fall_data) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    shreg_d   = {fall_data, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = fall_data;
                    state_d = STOP;
                end
                STOP: begin
                    if (fall_data && ((^shreg_q) ^ par_q)) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_byte = shreg_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// Host-side PS/2 mouse receiver: assembles 3-byte movement packets onto the ps2_mouse bus.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_mouse_rx_if.master  mouse
);

    logic                byte_valid;
    logic [7:0]          rx_byte;
    logic                err;
    logic                timeout;
    logic [1:0]          pkt_idx;
    logic [7:0]          status_q;
    logic [7:0]          x_q;
    logic [PACKET_W-1:0] mouse_q;
    logic                frame_err_q;

    ps2_byte_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (pkt_idx != 2'd0),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .err        (err),
        .timeout    (timeout)
    );

    // A status byte without its always-one bit is dropped so the stream realigns on packet boundaries.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pkt_idx     <= 2'd0;
            status_q    <= '0;
            x_q         <= '0;
            mouse_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err | timeout;
            if (err || timeout) begin
                pkt_idx <= 2'd0;
            end else if (byte_valid) begin
                case (pkt_idx)
                    2'd0: begin
                        if (rx_byte[STATUS_SYNC_BIT]) begin
                            status_q <= rx_byte;
                            pkt_idx  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        x_q     <= rx_byte;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        mouse_q[STATUS_LSB +: 8] <= status_q;
                        mouse_q[X_LSB +: 8]      <= x_q;
                        mouse_q[Y_LSB +: 8]      <= rx_byte;
                        mouse_q[TOGGLE_BIT]      <= ~mouse_q[TOGGLE_BIT];
                        pkt_idx                  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign mouse.ps2_mouse = mouse_q;
    assign mouse.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: table of packet sequences plus timeout, reset and latency cases.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

    localparam int TIMEOUT_CYC = 300;
    localparam int SYNC_STAGES = 2;
    localparam int HP          = 8;
    localparam int GAP         = 10;

    typedef struct {
        int             nbytes;
        logic [4:0][7:0] bytes;
        logic [4:0]     bad_par;
        logic [4:0]     bad_stop;
        logic [24:0]    exp_mouse;
        int             exp_errs;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int err_cnt = 0;
    int change_cyc = 0;
    int stop_edge_cyc = 0;
    logic [24:0] prev_mouse = '0;

    vec_t vecs[6];

    ps2_mouse_rx_if bus ();

    ps2_mouse_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .mouse    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Counting high cycles makes a stretched frame_err pulse show up as an extra error.
    always @(negedge clk_sys) begin
        if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (bus.ps2_mouse !== prev_mouse) change_cyc = cyc;
        prev_mouse = bus.ps2_mouse;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] b3, logic [7:0] b4, logic [4:0] bp,
                                logic [4:0] bs, logic [24:0] m, int e);
        vec_t v;
        v.nbytes    = n;
        v.bytes[0]  = b0;
        v.bytes[1]  = b1;
        v.bytes[2]  = b2;
        v.bytes[3]  = b3;
        v.bytes[4]  = b4;
        v.bad_par   = bp;
        v.bad_stop  = bs;
        v.exp_mouse = m;
        v.exp_errs  = e;
        return v;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_sys);
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(5);
    endtask

    // nbits < 8 stops after that many data bits, leaving the clock line held low.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits);
        ps2_data = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ps2_data = b[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            if (i == nbits - 1 && nbits < 8) return;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = (~^b) ^ bad_par;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
        ps2_data = ~bad_stop;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        stop_edge_cyc = cyc;
        wait_cyc(HP);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        send_frame(s, 1'b0, 1'b0, 8);
        send_frame(x, 1'b0, 1'b0, 8);
        send_frame(y, 1'b0, 1'b0, 8);
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset_dut();
        for (int k = 0; k < v.nbytes; k++) begin
            send_frame(v.bytes[k], v.bad_par[k], v.bad_stop[k], 8);
        end
        wait_cyc(20);
    endtask

    initial begin
        int e0;
        int lat;

        vecs[0] = mk(3, 8'h08, 8'h05, 8'hFB, 8'h00, 8'h00, 5'b00000, 5'b00000, 25'h1FB0508, 0);
        vecs[1] = mk(5, 8'h09, 8'h33, 8'h09, 8'h01, 8'h02, 5'b00010, 5'b00000, 25'h1020109, 1);
        vecs[2] = mk(4, 8'h00, 8'h08, 8'h10, 8'h20, 8'h00, 5'b00000, 5'b00000, 25'h1201008, 0);
        vecs[3] = mk(4, 8'h08, 8'h28, 8'hFF, 8'h01, 8'h00, 5'b00000, 5'b00001, 25'h101FF28, 1);
        vecs[4] = mk(3, 8'h18, 8'h80, 8'h7F, 8'h00, 8'h00, 5'b00000, 5'b00000, 25'h17F8018, 0);
        vecs[5] = mk(3, 8'h08, 8'h01, 8'h02, 8'h00, 8'h00, 5'b00100, 5'b00000, 25'h0000000, 1);

        wait_cyc(4);
        check_output("reset_mouse", 32'(bus.ps2_mouse), 32'h0);
        check_output("reset_frame_err", 32'(bus.frame_err), 32'h0);

        for (int i = 0; i < 6; i++) begin
            e0 = err_cnt;
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_mouse", i), 32'(bus.ps2_mouse), 32'(vecs[i].exp_mouse));
            check_output($sformatf("vec%0d_errs", i), 32'(err_cnt - e0), 32'(vecs[i].exp_errs));
        end

        // Clock stalls mid-frame long enough to trip the inactivity timeout.
        reset_dut();
        e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 5);
        wait_cyc(TIMEOUT_CYC + 40);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(20);
        check_output("timeout_errs", 32'(err_cnt - e0), 32'd1);
        check_output("timeout_mouse_hold", 32'(bus.ps2_mouse), 32'h0);
        send_packet(8'h08, 8'h01, 8'h01);
        wait_cyc(10);
        check_output("after_timeout_mouse", 32'(bus.ps2_mouse), 32'h1010108);
        check_output("after_timeout_errs", 32'(err_cnt - e0), 32'd1);

        // Reset asserted while the X byte is half received.
        reset_dut();
        e0 = err_cnt;
        send_packet(8'h08, 8'h05, 8'hFB);
        wait_cyc(10);
        check_output("pre_reset_mouse", 32'(bus.ps2_mouse), 32'h1FB0508);
        send_frame(8'h08, 1'b0, 1'b0, 8);
        send_frame(8'h05, 1'b0, 1'b0, 5);
        wait_cyc(3);
        reset_n = 1'b0;
        #2;
        check_output("midframe_reset_mouse", 32'(bus.ps2_mouse), 32'h0);
        wait_cyc(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        wait_cyc(10);
        send_packet(8'h0A, 8'h03, 8'h04);
        wait_cyc(10);
        check_output("post_reset_mouse", 32'(bus.ps2_mouse), 32'h104030A);
        check_output("post_reset_errs", 32'(err_cnt - e0), 32'd0);

        // Back-to-back packets: toggle alternates, update lands a fixed delay after the Y stop edge.
        reset_dut();
        send_packet(8'h08, 8'h01, 8'h02);
        lat = change_cyc - stop_edge_cyc;
        check_output("pkt1_mouse", 32'(bus.ps2_mouse), 32'h1020108);
        check_output("pkt1_latency", 32'(lat), 32'(SYNC_STAGES + 3));
        send_packet(8'h09, 8'h03, 8'h04);
        lat = change_cyc - stop_edge_cyc;
        check_output("pkt2_mouse", 32'(bus.ps2_mouse), 32'h0040309);
        check_output("pkt2_latency", 32'(lat), 32'(SYNC_STAGES + 3));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
